// File: rtl/cnt_share_sched_pkg.sv
// Shared definitions for the counter-sharing scheduler.
// Holds the FSM state type, the default hard terminal value and the
// index-width helper used to size DONE_ID and the round-robin pointer.
package cnt_share_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int unsigned MAXCNT_DEF = 5;

  // Never returns less than 1 so an index port always has a width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/cnt_share_sched_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req     - per-requester request vector
//   ptr     - index with highest priority this arbitration
//   win_oh  - one-hot winner (all zero when no request)
//   win_idx - binary index of the winner
//   any_req - at least one request is active
module rr_pick
  import cnt_share_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any_req
);

  int unsigned idx;
  logic        found;

  // Scan NREQ positions starting at ptr, wrapping; first hit wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = IW'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/cnt_share_sched.sv
// cnt_share_sched: round-robin scheduler owning one modulo up-counter that is
// shared by NREQ requesters. The granted requester runs the counter from 0 to
// its latched terminal value (clamped to MAXCNT); DONE pulses at the terminal
// value and the grant is released after a one-cycle gap.
// Ports:
//   CLK, RSTN - clock (rising edge), asynchronous active-low reset
//   REQ       - per-requester request; count enable while granted
//   LIMIT     - per-requester terminal count, slice i = LIMIT[i*CW +: CW]
//   ABORT     - kill the current run without DONE
//   GNT       - registered one-hot grant
//   BUSY      - high in RUN and GAP
//   CNT       - shared counter value
//   DONE      - one-cycle pulse when CNT reaches the latched limit
//   DONE_ID   - finishing requester index; holds between pulses
module cnt_share_sched
  import cnt_share_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned CW     = 3,
  parameter int unsigned MAXCNT = MAXCNT_DEF,
  localparam int unsigned IW    = clog2(NREQ)
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*CW-1:0] LIMIT,
  input  logic               ABORT,
  output logic [NREQ-1:0]    GNT,
  output logic               BUSY,
  output logic [CW-1:0]      CNT,
  output logic               DONE,
  output logic [IW-1:0]      DONE_ID
);

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, win, win_next, done_id_q, pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic            any_req, at_term;
  logic [CW-1:0]   lim, lim_raw, lim_sel;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (REQ),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any_req (any_req)
  );

  always_comb begin
    lim_raw = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) lim_raw = LIMIT[i*CW +: CW];
    end
    lim_sel = (lim_raw > CW'(MAXCNT)) ? CW'(MAXCNT) : lim_raw;
  end

  assign at_term  = (CNT == lim);
  assign win_next = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

  // State register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (any_req) state_nxt = ST_RUN;
      ST_RUN: begin
        if (ABORT)        state_nxt = ST_IDLE;
        else if (at_term) state_nxt = ST_GAP;
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    BUSY    = (state == ST_RUN) || (state == ST_GAP);
    DONE    = (state == ST_RUN) && at_term && !ABORT;
    DONE_ID = DONE ? win : done_id_q;
  end

  // Datapath: grant, counter, limit latch, pointer. Grant and counter are
  // cleared on the edge into GAP so both already read zero during GAP.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      GNT       <= '0;
      CNT       <= '0;
      lim       <= '0;
      win       <= '0;
      ptr       <= '0;
      done_id_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            GNT <= pick_oh;
            win <= pick_idx;
            lim <= lim_sel;
            CNT <= '0;
          end
        end
        ST_RUN: begin
          if (ABORT) begin
            GNT <= '0;
            CNT <= '0;
            ptr <= win_next;
          end else if (at_term) begin
            GNT       <= '0;
            CNT       <= '0;
            ptr       <= win_next;
            done_id_q <= win;
          end else if (REQ[win]) begin
            CNT <= CNT + 1'b1;
          end
        end
        default: begin
          GNT <= '0;
          CNT <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_share_sched.sv
module tb_cnt_share_sched;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [1:0] REQ = '0;
  logic [5:0] LIMIT = '0;
  logic       ABORT = 1'b0;
  logic [1:0] GNT;
  logic       BUSY;
  logic [2:0] CNT;
  logic       DONE;
  logic       DONE_ID;

  int checks = 0;
  int failures = 0;

  cnt_share_sched #(.NREQ(2), .CW(3), .MAXCNT(5)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .LIMIT(LIMIT), .ABORT(ABORT),
    .GNT(GNT), .BUSY(BUSY), .CNT(CNT), .DONE(DONE), .DONE_ID(DONE_ID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [5:0] limit;
    logic       abort;
    logic [1:0] gnt;
    logic       busy;
    logic [2:0] cnt;
    logic       done;
    logic       id;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic rst, logic [1:0] req, logic [5:0] limit,
                              logic abort, logic [1:0] gnt, logic busy,
                              logic [2:0] cnt, logic done, logic id);
    vec_t v;
    v.rst = rst; v.req = req; v.limit = limit; v.abort = abort;
    v.gnt = gnt; v.busy = busy; v.cnt = cnt; v.done = done; v.id = id;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQ = '0; ABORT = 1'b0; RSTN = 1'b0;
    #3;
    RSTN = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 2: single run, lim0=3
    add(1, 2'b01, 6'o03, 0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b01, 6'o03, 0, 2'b01, 1, 0, 0, 0);
    add(0, 2'b01, 6'o03, 0, 2'b01, 1, 1, 0, 0);
    add(0, 2'b01, 6'o03, 0, 2'b01, 1, 2, 0, 0);
    add(0, 2'b01, 6'o03, 0, 2'b01, 1, 3, 1, 0);
    add(0, 2'b00, 6'o03, 0, 2'b00, 1, 0, 0, 0);
    add(0, 2'b00, 6'o03, 0, 2'b00, 0, 0, 0, 0);
    // Test 3: round robin, both limits 1
    add(1, 2'b11, 6'o11, 0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 6'o11, 0, 2'b01, 1, 0, 0, 0);
    add(0, 2'b11, 6'o11, 0, 2'b01, 1, 1, 1, 0);
    add(0, 2'b11, 6'o11, 0, 2'b00, 1, 0, 0, 0);
    add(0, 2'b11, 6'o11, 0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 6'o11, 0, 2'b10, 1, 0, 0, 0);
    add(0, 2'b11, 6'o11, 0, 2'b10, 1, 1, 1, 1);
    add(0, 2'b11, 6'o11, 0, 2'b00, 1, 0, 0, 1);
    add(0, 2'b11, 6'o11, 0, 2'b00, 0, 0, 0, 1);
    add(0, 2'b11, 6'o11, 0, 2'b01, 1, 0, 0, 1);
    add(0, 2'b11, 6'o11, 0, 2'b01, 1, 1, 1, 0);
    add(0, 2'b11, 6'o11, 0, 2'b00, 1, 0, 0, 0);
    // Test 4: lim0=7 clamps to 5, lim1=0 finishes immediately
    add(0, 2'b01, 6'o07, 0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b01, 6'o07, 0, 2'b01, 1, 0, 0, 0);
    add(0, 2'b01, 6'o07, 0, 2'b01, 1, 1, 0, 0);
    add(0, 2'b01, 6'o07, 0, 2'b01, 1, 2, 0, 0);
    add(0, 2'b01, 6'o07, 0, 2'b01, 1, 3, 0, 0);
    add(0, 2'b01, 6'o07, 0, 2'b01, 1, 4, 0, 0);
    add(0, 2'b01, 6'o07, 0, 2'b01, 1, 5, 1, 0);
    add(0, 2'b10, 6'o07, 1, 2'b00, 1, 0, 0, 0);
    add(0, 2'b10, 6'o07, 0, 2'b00, 0, 0, 0, 0);
    add(0, 2'b10, 6'o07, 0, 2'b10, 1, 0, 1, 1);
    add(0, 2'b00, 6'o07, 0, 2'b00, 1, 0, 0, 1);
    add(0, 2'b00, 6'o07, 1, 2'b00, 0, 0, 0, 1);
    add(0, 2'b00, 6'o07, 0, 2'b00, 0, 0, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset();
      REQ = vq[i].req; LIMIT = vq[i].limit; ABORT = vq[i].abort;
      #1;
      check($sformatf("row%0d gnt", i),  32'(GNT),     32'(vq[i].gnt));
      check($sformatf("row%0d busy", i), 32'(BUSY),    32'(vq[i].busy));
      check($sformatf("row%0d cnt", i),  32'(CNT),     32'(vq[i].cnt));
      check($sformatf("row%0d done", i), 32'(DONE),    32'(vq[i].done));
      check($sformatf("row%0d id", i),   32'(DONE_ID), 32'(vq[i].id));
      tick();
    end

    // Test 1: async reset in the middle of requester 1's run at CNT=3
    do_reset();
    REQ = 2'b01; LIMIT = 6'o50;          // lim1=5, lim0=0
    tick(); tick(); tick();              // RUN(done) -> GAP -> IDLE, ptr=1
    REQ = 2'b11;
    tick();
    check("t1 gnt1", 32'(GNT), 32'd2);
    begin
      int n;
      n = 0;
      while (CNT != 3'd3 && n < 20) begin tick(); n++; end
      check("t1 reach cnt3", 32'(CNT), 32'd3);
    end
    RSTN = 1'b0;
    #1;
    check("t1 rst gnt",  32'(GNT),  32'd0);
    check("t1 rst cnt",  32'(CNT),  32'd0);
    check("t1 rst busy", 32'(BUSY), 32'd0);
    check("t1 rst done", 32'(DONE), 32'd0);
    #2;
    RSTN = 1'b1;
    tick();
    check("t1 regrant", 32'(GNT), 32'd1);

    // Test 5: pause then abort
    do_reset();
    REQ = 2'b01; LIMIT = 6'o15;          // lim1=1, lim0=5
    tick(); tick(); tick();
    check("t5 cnt2", 32'(CNT), 32'd2);
    REQ = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t5 hold cnt%0d", k), 32'(CNT), 32'd2);
      check($sformatf("t5 hold gnt%0d", k), 32'(GNT), 32'd1);
    end
    ABORT = 1'b1;
    #1;
    check("t5 abort done", 32'(DONE), 32'd0);
    tick();
    check("t5 abort gnt",  32'(GNT),  32'd0);
    check("t5 abort cnt",  32'(CNT),  32'd0);
    check("t5 abort busy", 32'(BUSY), 32'd0);
    ABORT = 1'b0; REQ = 2'b11;
    tick();
    check("t5 next gnt", 32'(GNT), 32'd2);

    // Test 6: abort in the terminal cycle
    do_reset();
    REQ = 2'b01; LIMIT = 6'o01;
    tick(); tick();
    ABORT = 1'b1;
    #1;
    check("t6 cnt", 32'(CNT), 32'd1);
    check("t6 done", 32'(DONE), 32'd0);
    tick();
    check("t6 busy", 32'(BUSY), 32'd0);
    check("t6 gnt",  32'(GNT),  32'd0);
    ABORT = 1'b0; REQ = 2'b11;
    tick();
    check("t6 next gnt", 32'(GNT), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
